// File: rtl/fetch_unit_if.sv
// fetch_unit_if: every signal fetch_unit exchanges with its neighbours.
//   PC side     : pc_addr in; pc_nxt / pc_load / pc_ld_addr out
//   ROM side    : rom_req / rom_addr out; rom_ack / rom_data in
//   Decode side : ir / ir_pc / ir_valid out; ir_ready in
//   Execute side: redirect / redirect_addr in
//   Debug       : dbg_state out (current fetch FSM state)
// master = fetch_unit, slave = surrounding logic (PC, ROM, decode, execute).
//
// Handshake semantics:
//   Decode: an instruction transfers on a posedge where ir_valid && ir_ready.
//   ir_valid is held with ir/ir_pc stable until that transfer or a redirect.
//   ROM: rom_req with rom_addr is held stable until a posedge with rom_ack=1;
//   rom_data is meaningful only while rom_ack=1.
interface fetch_unit_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] pc_addr;
    logic          pc_nxt;
    logic          pc_load;
    logic [AW-1:0] pc_ld_addr;

    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack;
    logic [DW-1:0] rom_data;

    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;

    logic          redirect;
    logic [AW-1:0] redirect_addr;

    logic [2:0]    dbg_state;

    modport master (
        input  pc_addr, rom_ack, rom_data, ir_ready, redirect, redirect_addr,
        output pc_nxt, pc_load, pc_ld_addr, rom_req, rom_addr,
               ir, ir_pc, ir_valid, dbg_state
    );

    modport slave (
        output pc_addr, rom_ack, rom_data, ir_ready, redirect, redirect_addr,
        input  pc_nxt, pc_load, pc_ld_addr, rom_req, rom_addr,
               ir, ir_pc, ir_valid, dbg_state
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC and decode.
// Samples pc_addr, reads the instruction ROM with a req/ack handshake,
// and presents the word to decode in ir with a valid/ready handshake.
// A one-entry skid buffer absorbs a fetch that completes while decode
// is stalled. Drives the PC's advance (pc_nxt) and load (pc_load) strobes.
// Ports:
//   clk   - system clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   bus   - fetch_unit_if.master (PC, ROM, decode, redirect, debug state)
// All outputs are registered.
module fetch_unit #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_STALL = 3'd3;
    localparam logic [2:0] ST_LOAD  = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    logic [2:0]    state_q;
    logic          pc_nxt_q;
    logic          pc_load_q;
    logic [AW-1:0] pc_ld_addr_q;
    logic          rom_req_q;
    logic [AW-1:0] rom_addr_q;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] ir_pc_q;
    logic          ir_valid_q;
    logic          sk_valid_q;
    logic [DW-1:0] sk_data_q;
    logic [AW-1:0] sk_pc_q;

    logic          consume;

    always_comb begin
        consume = ir_valid_q && bus.ir_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_nxt_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_ld_addr_q <= '0;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= '0;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            ir_valid_q   <= 1'b0;
            sk_valid_q   <= 1'b0;
            sk_data_q    <= '0;
            sk_pc_q      <= '0;
        end else begin
            // PC strobes are single-cycle pulses unless re-armed below.
            pc_nxt_q  <= 1'b0;
            pc_load_q <= 1'b0;

            if (state_q == ST_IDLE) begin
                // IDLE never looks at rom_ack, so a stray ack left over
                // from before reset is dropped here.
                state_q    <= ST_REQ;
                rom_req_q  <= 1'b1;
                rom_addr_q <= bus.pc_addr;
            end else if (bus.redirect) begin
                // Redirect beats every other event: the pipeline contents
                // and any word acked this cycle are stale.
                pc_load_q    <= 1'b1;
                pc_ld_addr_q <= bus.redirect_addr;
                ir_valid_q   <= 1'b0;
                sk_valid_q   <= 1'b0;
                if ((state_q == ST_REQ || state_q == ST_FLUSH) && !bus.rom_ack) begin
                    // A read is still outstanding; keep the request
                    // (same address) up until the ROM acks it.
                    state_q <= ST_FLUSH;
                end else begin
                    state_q   <= ST_LOAD;
                    rom_req_q <= 1'b0;
                end
            end else begin
                if (consume) begin
                    if (sk_valid_q) begin
                        ir_q       <= sk_data_q;
                        ir_pc_q    <= sk_pc_q;
                        sk_valid_q <= 1'b0;
                    end else begin
                        // Overridden below if a new word lands this cycle.
                        ir_valid_q <= 1'b0;
                    end
                end

                case (state_q)
                    ST_REQ: begin
                        if (bus.rom_ack) begin
                            if (!ir_valid_q || (consume && !sk_valid_q)) begin
                                ir_q       <= bus.rom_data;
                                ir_pc_q    <= rom_addr_q;
                                ir_valid_q <= 1'b1;
                            end else begin
                                sk_data_q  <= bus.rom_data;
                                sk_pc_q    <= rom_addr_q;
                                sk_valid_q <= 1'b1;
                            end
                            pc_nxt_q  <= 1'b1;
                            rom_req_q <= 1'b0;
                            state_q   <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        // The PC advanced at the negedge inside this cycle,
                        // so pc_addr already holds the next address.
                        if (sk_valid_q && !consume) begin
                            state_q <= ST_STALL;
                        end else begin
                            state_q    <= ST_REQ;
                            rom_req_q  <= 1'b1;
                            rom_addr_q <= bus.pc_addr;
                        end
                    end
                    ST_STALL: begin
                        if (consume) begin
                            state_q    <= ST_REQ;
                            rom_req_q  <= 1'b1;
                            rom_addr_q <= bus.pc_addr;
                        end
                    end
                    ST_LOAD: begin
                        state_q    <= ST_REQ;
                        rom_req_q  <= 1'b1;
                        rom_addr_q <= bus.pc_addr;
                    end
                    ST_FLUSH: begin
                        if (bus.rom_ack) begin
                            state_q   <= ST_LOAD;
                            rom_req_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        rom_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pc_nxt     = pc_nxt_q;
    assign bus.pc_load    = pc_load_q;
    assign bus.pc_ld_addr = pc_ld_addr_q;
    assign bus.rom_req    = rom_req_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.ir         = ir_q;
    assign bus.ir_pc      = ir_pc_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Environment models: a PC that loads/increments on negedge clk, and a ROM
// holding mem[a] = 0x1000 + a with programmable ack latency. A per-cycle
// compare routine tracks the instruction stream decode must see (sequential
// addresses, restarting at each redirect target) and the ROM/PC protocol
// rules; directed steps add hand-computed literal expectations.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if #(.AW(16), .DW(16)) bus ();

    fetch_unit #(.AW(16), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- environment ----------------
    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    int   lat = 0;
    logic ack_force = 1'b0;
    int   rom_cnt = 0;

    always @(posedge clk) begin
        if (!bus.rom_req || bus.rom_ack) rom_cnt <= 0;
        else rom_cnt <= rom_cnt + 1;
    end

    assign bus.rom_ack  = ack_force || (bus.rom_req && rom_cnt == lat);
    assign bus.rom_data = ack_force ? 16'hDEAD : mem(bus.rom_addr);

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) bus.pc_addr <= 16'h0000;
        else if (bus.pc_load) bus.pc_addr <= bus.pc_ld_addr;
        else if (bus.pc_nxt) bus.pc_addr <= bus.pc_addr + 16'd1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [15:0] exp_addr = 16'h0000;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          nxt_cnt = 0;
    int          cons_cnt = 0;

    // Runs at each negedge: inputs and outputs are the values the DUT
    // will act on at the coming posedge.
    task automatic compare_cycle();
        if (!rst_n) begin
            exp_addr = 16'h0000;
            pend     = 1'b0;
            nxt_cnt  = 0;
            cons_cnt = 0;
            return;
        end
        check("pc_strobe_excl", {31'd0, bus.pc_nxt & bus.pc_load}, 32'd0);
        if (pend) begin
            check("rom_req_hold", {31'd0, bus.rom_req}, 32'd1);
            check("rom_addr_hold", {16'd0, bus.rom_addr}, {16'd0, pend_addr});
        end
        if (bus.ir_valid)
            check("ir_matches_pc", {16'd0, bus.ir}, {16'd0, mem(bus.ir_pc)});
        if (bus.redirect) begin
            exp_addr = bus.redirect_addr;
        end else if (bus.ir_valid && bus.ir_ready) begin
            check("stream_ir_pc", {16'd0, bus.ir_pc}, {16'd0, exp_addr});
            check("stream_ir", {16'd0, bus.ir}, {16'd0, mem(exp_addr)});
            exp_addr = exp_addr + 16'd1;
            cons_cnt++;
        end
        if (bus.pc_nxt) nxt_cnt++;
        pend      = bus.rom_req && !bus.rom_ack;
        pend_addr = bus.rom_addr;
    endtask

    // One cycle: compare at negedge, then land 2 time units after posedge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst_n = 1'b0;
        lat = l;
        ack_force = 1'b0;
        bus.ir_ready = rdy;
        bus.redirect = 1'b0;
        bus.redirect_addr = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_nxt"}, {31'd0, bus.pc_nxt}, 32'd0);
        check({tag, "_pc_load"}, {31'd0, bus.pc_load}, 32'd0);
        check({tag, "_pc_ld_addr"}, {16'd0, bus.pc_ld_addr}, 32'd0);
        check({tag, "_rom_req"}, {31'd0, bus.rom_req}, 32'd0);
        check({tag, "_rom_addr"}, {16'd0, bus.rom_addr}, 32'd0);
        check({tag, "_ir"}, {16'd0, bus.ir}, 32'd0);
        check({tag, "_ir_pc"}, {16'd0, bus.ir_pc}, 32'd0);
        check({tag, "_ir_valid"}, {31'd0, bus.ir_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = 16'h0000;

        // ---- power-on reset ----
        tick();
        tick();
        check_all_zero("por");

        // ---- A: zero-latency ROM, decode always ready ----
        do_reset(0, 1'b1);
        tick();
        check("a_pe1_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("a_pe1_rom_req", {31'd0, bus.rom_req}, 32'd1);
        check("a_pe1_rom_addr", {16'd0, bus.rom_addr}, 32'h0000);
        tick();
        check("a_first_valid", {31'd0, bus.ir_valid}, 32'd1);
        check("a_first_ir", {16'd0, bus.ir}, 32'h1000);
        check("a_first_ir_pc", {16'd0, bus.ir_pc}, 32'h0000);
        check("a_first_pc_nxt", {31'd0, bus.pc_nxt}, 32'd1);
        tick();
        check("a_step_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("a_step_pc_nxt", {31'd0, bus.pc_nxt}, 32'd0);
        check("a_second_rom_addr", {16'd0, bus.rom_addr}, 32'h0001);
        tick();
        check("a_second_ir", {16'd0, bus.ir}, 32'h1001);
        tick();
        tick();
        check("a_third_ir", {16'd0, bus.ir}, 32'h1002);
        repeat (20) tick();
        check("a_nxt_per_fetch", nxt_cnt, cons_cnt);

        // ---- B: ROM latency 3, 20 fetches ----
        do_reset(3, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b_req_held", {31'd0, bus.rom_req}, 32'd1);
            check("b_addr_const", {16'd0, bus.rom_addr}, 32'h0000);
            check("b_no_ir_yet", {31'd0, bus.ir_valid}, 32'd0);
            tick();
        end
        check("b_req_drop", {31'd0, bus.rom_req}, 32'd0);
        check("b_first_ir", {16'd0, bus.ir}, 32'h1000);
        check("b_first_nxt", {31'd0, bus.pc_nxt}, 32'd1);
        n = 0;
        while (cons_cnt < 20 && n < 400) begin
            tick();
            n++;
        end
        check("b_fetch_timeout", {31'd0, n < 400}, 32'd1);
        check("b_nxt_per_fetch", nxt_cnt, cons_cnt);

        // ---- C: decode stalled, skid buffer ----
        do_reset(0, 1'b0);
        tick();
        tick();
        check("c_ir_first", {16'd0, bus.ir}, 32'h1000);
        tick();
        tick();
        check("c_skid_fill_ir", {16'd0, bus.ir}, 32'h1000);
        check("c_skid_fill_nxt", {31'd0, bus.pc_nxt}, 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("c_stall_no_req", {31'd0, bus.rom_req}, 32'd0);
            check("c_stall_ir_held", {16'd0, bus.ir}, 32'h1000);
            check("c_stall_valid", {31'd0, bus.ir_valid}, 32'd1);
            tick();
        end
        bus.ir_ready = 1'b1;
        tick();
        check("c_skid_to_ir", {16'd0, bus.ir}, 32'h1001);
        check("c_skid_to_ir_pc", {16'd0, bus.ir_pc}, 32'h0001);
        check("c_resume_req", {31'd0, bus.rom_req}, 32'd1);
        check("c_resume_addr", {16'd0, bus.rom_addr}, 32'h0002);
        tick();
        check("c_next_ir", {16'd0, bus.ir}, 32'h1002);
        repeat (6) tick();

        // ---- D: redirect while in STEP ----
        do_reset(0, 1'b1);
        tick();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        check("d_pc_load", {31'd0, bus.pc_load}, 32'd1);
        check("d_pc_ld_addr", {16'd0, bus.pc_ld_addr}, 32'h0040);
        check("d_ir_valid_clr", {31'd0, bus.ir_valid}, 32'd0);
        check("d_pc_nxt_clr", {31'd0, bus.pc_nxt}, 32'd0);
        tick();
        check("d_load_pulse_end", {31'd0, bus.pc_load}, 32'd0);
        check("d_req_target", {16'd0, bus.rom_addr}, 32'h0040);
        tick();
        check("d_ir_target", {16'd0, bus.ir}, 32'h1040);
        check("d_ir_pc_target", {16'd0, bus.ir_pc}, 32'h0040);
        repeat (6) tick();

        // ---- E: redirect during REQ with latency 4, re-redirect in FLUSH ----
        do_reset(4, 1'b1);
        tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 16'h0020;
        tick();
        check("e_load1", {31'd0, bus.pc_load}, 32'd1);
        check("e_load1_addr", {16'd0, bus.pc_ld_addr}, 32'h0020);
        check("e_flush_req", {31'd0, bus.rom_req}, 32'd1);
        check("e_flush_addr", {16'd0, bus.rom_addr}, 32'h0000);
        bus.redirect_addr = 16'h0080;
        tick();
        bus.redirect = 1'b0;
        check("e_load2", {31'd0, bus.pc_load}, 32'd1);
        check("e_load2_addr", {16'd0, bus.pc_ld_addr}, 32'h0080);
        check("e_flush_addr2", {16'd0, bus.rom_addr}, 32'h0000);
        tick();
        check("e_flush_req3", {31'd0, bus.rom_req}, 32'd1);
        check("e_flush_addr3", {16'd0, bus.rom_addr}, 32'h0000);
        n = 0;
        while (!bus.ir_valid && n < 40) begin
            tick();
            n++;
        end
        check("e_fetch_timeout", {31'd0, n < 40}, 32'd1);
        check("e_ir_pc", {16'd0, bus.ir_pc}, 32'h0080);
        check("e_ir", {16'd0, bus.ir}, 32'h1080);
        repeat (4) tick();

        // ---- F: reset mid-request, stray ack after release ----
        do_reset(4, 1'b0);
        n = 0;
        while (!(bus.rom_req && bus.rom_addr == 16'h0001) && n < 40) begin
            tick();
            n++;
        end
        check("f_setup_timeout", {31'd0, n < 40}, 32'd1);
        check("f_setup_valid", {31'd0, bus.ir_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("f_async");
        tick();
        rst_n = 1'b1;
        ack_force = 1'b1;
        lat = 0;
        bus.ir_ready = 1'b1;
        tick();
        ack_force = 1'b0;
        check("f_idle_no_capture", {31'd0, bus.ir_valid}, 32'd0);
        check("f_restart_req", {31'd0, bus.rom_req}, 32'd1);
        check("f_restart_addr", {16'd0, bus.rom_addr}, 32'h0000);
        tick();
        check("f_restart_ir", {16'd0, bus.ir}, 32'h1000);
        check("f_restart_ir_pc", {16'd0, bus.ir_pc}, 32'h0000);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
